// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, issues I-cache reads and fills a one-entry IF/ID buffer.
// Latency: a completed access appears on id_valid one edge later; sustains 1 instr/cycle.
// Backpressure: no new request while the buffer is full and id_ready=0; an issued request is held through stalls.
// Optional feature macro: PREDECODE_JAL_EN (jal targets are followed directly at capture).
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            icache_ren,
    output logic [XLEN-1:0] icache_addr,
    input  logic            icache_stall,
    input  logic [XLEN-1:0] icache_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    // FETCH: free to issue at pc; WAIT: holding a stalled request whose data is wanted;
    // DRAIN: holding a stalled request whose data will be thrown away after a redirect.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            free;
    logic            capture;
    logic            hold_req;
    logic [XLEN-1:0] cap_pc;
    logic [XLEN-1:0] next_pc;

    assign free = !id_valid || id_ready;

    // Request outputs and next state; the held request in WAIT/DRAIN ignores id_ready and redirects.
    always_comb begin
        icache_ren  = 1'b0;
        icache_addr = pc;
        state_nxt   = FETCH;
        case (state)
            FETCH: begin
                icache_ren  = free;
                icache_addr = pc;
                if (free && icache_stall)
                    state_nxt = redirect_valid ? DRAIN : WAIT;
                else
                    state_nxt = FETCH;
            end
            WAIT: begin
                icache_ren  = 1'b1;
                icache_addr = req_pc;
                if (icache_stall)
                    state_nxt = redirect_valid ? DRAIN : WAIT;
                else
                    state_nxt = FETCH;
            end
            DRAIN: begin
                icache_ren  = 1'b1;
                icache_addr = req_pc;
                state_nxt   = icache_stall ? DRAIN : FETCH;
            end
            default: begin
                icache_ren  = 1'b0;
                icache_addr = pc;
                state_nxt   = FETCH;
            end
        endcase
    end

    // A completion is kept only when no redirect is arriving and the access is not being drained.
    always_comb begin
        capture  = !redirect_valid && !icache_stall &&
                   ((state == FETCH && free) || state == WAIT);
        hold_req = (state == FETCH) && free && icache_stall;
        cap_pc   = (state == WAIT) ? req_pc : pc;
`ifdef PREDECODE_JAL_EN
        if (icache_rdata[6:0] == 7'b1101111)
            next_pc = cap_pc + {{(XLEN-21){icache_rdata[31]}}, icache_rdata[31],
                                icache_rdata[19:12], icache_rdata[20],
                                icache_rdata[30:21], 1'b0};
        else
            next_pc = cap_pc + XLEN'(4);
`else
        next_pc = cap_pc + XLEN'(4);
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // PC, held request address and IF/ID buffer; redirect beats capture and transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            id_valid <= 1'b0;
            id_inst  <= '0;
            id_pc    <= '0;
        end else begin
            if (hold_req)
                req_pc <= pc;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                id_valid <= 1'b0;
            end else if (capture) begin
                pc       <= next_pc;
                id_valid <= 1'b1;
                id_inst  <= icache_rdata;
                id_pc    <= cap_pc;
            end else if (id_valid && id_ready) begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table then randomized traffic against a reference model.
// Latency: inputs applied after negedge, outputs checked 1ns later, model advanced at posedge.
// Backpressure: id_ready, icache_stall and redirects are all exercised.
module tb_fetch_ctrl;

    localparam logic [31:0] JALW = 32'h0080006F;
`ifdef PREDECODE_JAL_EN
    localparam logic [31:0] JN = 32'h48;
`else
    localparam logic [31:0] JN = 32'h44;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_ren;
    logic [31:0] icache_addr;
    logic        icache_stall;
    logic [31:0] icache_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .icache_ren(icache_ren), .icache_addr(icache_addr),
        .icache_stall(icache_stall), .icache_rdata(icache_rdata),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Reference model: one outstanding-access record, a PC and a one-entry buffer.
    logic        m_out_active, m_out_discard;
    logic [31:0] m_out_addr;
    logic [31:0] m_pc;
    logic        m_bvalid;
    logic [31:0] m_binst, m_bpc;

    function automatic logic m_ren();
        return m_out_active ? 1'b1 : (!m_bvalid || id_ready);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_out_active ? m_out_addr : m_pc;
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a, input logic [31:0] inst);
        int off;
        off = 4;
`ifdef PREDECODE_JAL_EN
        if (inst[6:0] == 7'h6F) begin
            off = (inst[31] ? -(1 << 20) : 0) + (int'(inst[19:12]) << 12)
                + (int'(inst[20]) << 11) + (int'(inst[30:21]) << 1);
        end
`endif
        return a + 32'(off);
    endfunction

    task automatic m_reset();
        m_out_active = 0; m_out_discard = 0; m_out_addr = 0;
        m_pc = 0; m_bvalid = 0; m_binst = 0; m_bpc = 0;
    endtask

    task automatic m_update();
        logic        ren, comp, keep;
        logic [31:0] a;
        ren  = m_ren();
        a    = m_addr();
        comp = ren && !icache_stall;
        if (redirect_valid) begin
            m_pc     = redirect_pc;
            m_bvalid = 0;
            if (ren && icache_stall) begin
                m_out_active = 1; m_out_addr = a; m_out_discard = 1;
            end else begin
                m_out_active = 0; m_out_discard = 0;
            end
        end else begin
            keep = comp && !(m_out_active && m_out_discard);
            if (keep) begin
                m_bvalid = 1; m_binst = icache_rdata; m_bpc = a;
                m_pc = m_next(a, icache_rdata);
            end else if (m_bvalid && id_ready) begin
                m_bvalid = 0;
            end
            if (ren && icache_stall) begin
                m_out_discard = m_out_active ? m_out_discard : 1'b0;
                m_out_active  = 1; m_out_addr = a;
            end else begin
                m_out_active = 0; m_out_discard = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic st, input logic [31:0] rd, input logic rdy,
                         input logic rv, input logic [31:0] rp);
        icache_stall = st; icache_rdata = rd; id_ready = rdy;
        redirect_valid = rv; redirect_pc = rp;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    typedef struct {
        logic        st, rdy, rv;
        logic [31:0] rpc;
        logic        ren;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] idpc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic rdy, logic rv, logic [31:0] rpc,
                                logic ren, logic [31:0] addr, logic vld, logic [31:0] idpc);
        vec_t v;
        v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ren = ren; v.addr = addr; v.vld = vld; v.idpc = idpc;
        return v;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == 32'h40) ? JALW : (32'hA000_0000 | a);
    endfunction

    initial begin
        logic [31:0] r, rd;
        //              st rdy rv rpc            ren addr          vld idpc
        // back-to-back fetch from reset
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h4,         1, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h8,         1, 32'h4));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'hC,         1, 32'h8));
        // 3-cycle stall at 0x10
        tbl.push_back(mk(1, 1, 0, 0,            1, 32'h10,        1, 32'hC));
        tbl.push_back(mk(1, 1, 0, 0,            1, 32'h10,        0, 32'hC));
        tbl.push_back(mk(1, 1, 0, 0,            1, 32'h10,        0, 32'hC));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h10,        0, 32'hC));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h14,        1, 32'h10));
        // decode backpressure
        tbl.push_back(mk(0, 0, 0, 0,            0, 32'h18,        1, 32'h14));
        tbl.push_back(mk(0, 0, 0, 0,            0, 32'h18,        1, 32'h14));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h18,        1, 32'h14));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h1C,        1, 32'h18));
        // redirect to 0x100 during stalled access at 0x20
        tbl.push_back(mk(1, 1, 0, 0,            1, 32'h20,        1, 32'h1C));
        tbl.push_back(mk(1, 1, 1, 32'h100,      1, 32'h20,        0, 32'h1C));
        tbl.push_back(mk(1, 1, 0, 0,            1, 32'h20,        0, 32'h1C));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h20,        0, 32'h1C));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h100,       0, 32'h1C));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h104,       1, 32'h100));
        // redirect on unstalled completion with id_ready=0 (from WAIT, then from FETCH)
        tbl.push_back(mk(1, 1, 0, 0,            1, 32'h108,       1, 32'h104));
        tbl.push_back(mk(0, 0, 1, 32'h200,      1, 32'h108,       0, 32'h104));
        tbl.push_back(mk(0, 0, 1, 32'h300,      1, 32'h200,       0, 32'h104));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h300,       0, 32'h104));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h304,       1, 32'h300));
        // jal at 0x40
        tbl.push_back(mk(0, 1, 1, 32'h40,       1, 32'h308,       1, 32'h304));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h40,        0, 32'h304));
        tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFF8, 1, JN,           1, 32'h40));
        // PC wrap
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'hFFFF_FFF8, 0, 32'h40));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h0,         1, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h4,         1, 32'h0));
        // redirect into DRAIN, then a second redirect while draining (last wins)
        tbl.push_back(mk(1, 1, 1, 32'h500,      1, 32'h8,         1, 32'h4));
        tbl.push_back(mk(1, 1, 1, 32'h600,      1, 32'h8,         0, 32'h4));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h8,         0, 32'h4));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h600,       0, 32'h4));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h604,       1, 32'h600));

        rst = 1'b1;
        apply(0, 0, 0, 0, 0);
        m_reset();
        @(negedge clk);
        chk("reset ren", {31'b0, icache_ren}, 32'h1);
        chk("reset addr", icache_addr, 32'h0);
        chk("reset id_valid", {31'b0, id_valid}, 32'h0);
        chk("reset id_pc", id_pc, 32'h0);
        chk("reset id_inst", id_inst, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i].st, word_at(tbl[i].addr), tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            chk($sformatf("row%0d ren", i), {31'b0, icache_ren}, {31'b0, tbl[i].ren});
            chk($sformatf("row%0d addr", i), icache_addr, tbl[i].addr);
            chk($sformatf("row%0d id_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].vld});
            chk($sformatf("row%0d id_pc", i), id_pc, tbl[i].idpc);
            if (tbl[i].vld)
                chk($sformatf("row%0d id_inst", i), id_inst, word_at(tbl[i].idpc));
            advance();
        end

        for (int i = 0; i < 3000; i++) begin
            r  = $urandom();
            rd = ($urandom_range(0, 4) == 0) ? {r[31:7], 7'h6F} : r;
            apply($urandom_range(0, 9) < 3, rd, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) == 0, $urandom() & 32'hFFFF_FFFC);
            chk($sformatf("rnd%0d ren", i), {31'b0, icache_ren}, {31'b0, m_ren()});
            chk($sformatf("rnd%0d addr", i), icache_addr, m_addr());
            chk($sformatf("rnd%0d id_valid", i), {31'b0, id_valid}, {31'b0, m_bvalid});
            chk($sformatf("rnd%0d id_pc", i), id_pc, m_bpc);
            chk($sformatf("rnd%0d id_inst", i), id_inst, m_binst);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-issue RISC-V core. Owns the PC and drives the I-cache request handshake, holding each request stable through cache stalls. Buffers the fetched word in a one-entry IF/ID register that feeds decode and the immediate generator through a valid/ready handshake. Handles branch/jump redirects from EX, including discarding a cache access already in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, width of PC, addresses and instruction word.

Ports:
clk  input  1  core clock, rising edge.
rst  input  1  asynchronous, active-high reset.
icache_ren  output  1  I-cache read request.
icache_addr  output  XLEN  byte address of the request.
icache_stall  input  1  cache busy; an access completes in any cycle with icache_ren=1 and icache_stall=0.
icache_rdata  input  XLEN  instruction word, valid in the completing cycle.
id_valid  output  1  IF/ID register holds a valid instruction.
id_inst  output  XLEN  buffered instruction.
id_pc  output  XLEN  PC of id_inst.
id_ready  input  1  decode accepts; a transfer occurs when id_valid and id_ready are both 1.
redirect_valid  input  1  EX redirect request (taken branch, jal, jalr, flush).
redirect_pc  input  XLEN  redirect target.

Behaviour:
- Reset, asynchronous: state=FETCH, pc=RESET_PC, req_pc=0, id_valid=0, id_inst=0, id_pc=0.
- Buffer free condition: free = !id_valid || id_ready.
- Outputs by state:
  - FETCH: icache_ren = free, icache_addr = pc.
  - WAIT: icache_ren = 1, icache_addr = req_pc.
  - DRAIN: icache_ren = 1, icache_addr = req_pc.
- Once icache_ren is raised, it and icache_addr stay constant until the completing cycle. id_ready, redirect_valid and reset-release never change them mid-access.
- A transfer (id_valid && id_ready) with no new capture clears id_valid next cycle.
- FETCH, no redirect:
  - ren=1 and stall=0: capture. id_inst<=icache_rdata, id_pc<=pc, id_valid<=1, pc<=next_pc. Stay in FETCH. This gives a sustained rate of 1 instruction/cycle.
  - ren=1 and stall=1: req_pc<=pc, go to WAIT.
- WAIT, no redirect, stall=0: capture as above using id_pc<=req_pc, then go to FETCH. The buffer is guaranteed empty here, because entry into WAIT required free=1.
- Redirect has priority over capture and transfer in every state. The same edge applies:
  - pc<=redirect_pc.
  - id_valid<=0, and a same-cycle completion is discarded.
- Next state on redirect:
  - FETCH with ren=1, stall=1: req_pc<=pc (old), go to DRAIN.
  - WAIT with stall=1: go to DRAIN.
  - WAIT with stall=0: go to FETCH.
  - FETCH otherwise: stay in FETCH.
- DRAIN: hold the old access. On stall=0, discard the data, leave id_valid=0, go to FETCH; the next request uses the redirected pc. A further redirect in DRAIN overwrites pc (last wins) and stays in DRAIN.
- next_pc = pc+4, modulo 2^XLEN. Wrap from 32'hFFFF_FFFC to 0 is silent.
- Latency: request-to-id_valid is 1 edge after completion. Redirect-to-first new request is the next cycle from FETCH, or after drain completion from WAIT/DRAIN.
- No state other than FETCH/WAIT/DRAIN is reachable; an illegal encoding returns to FETCH.

Optional Feature:
PREDECODE_JAL_EN.
- Defined: on capture, if icache_rdata[6:0]==7'b1101111 (jal), next_pc = captured pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}). Applies in both FETCH and WAIT captures. The EX redirect for that jal is still accepted and behaves identically.
- Undefined: next_pc is always pc+4; no opcode inspection in fetch.

Test Plan:
- Reset release, cache never stalls, id_ready=1 -> icache_addr 0,4,8,12 on consecutive cycles; id_pc 0,4,8 one cycle behind, id_valid held 1.
- icache_stall=1 for 3 cycles on the request at 0x10 -> icache_ren/addr=0x10 stable for 4 cycles; single capture id_pc=0x10; next request is 0x14.
- Sustained fetch, id_ready=0 for 2 cycles while id_valid=1 -> icache_ren=0, id_inst/id_pc unchanged; on id_ready=1 the request resumes at the next PC with no drop or duplicate.
- redirect_valid, redirect_pc=0x100 while the access at 0x20 is stalled 2 more cycles -> addr stays 0x20 until completion; data discarded, id_valid=0; next request 0x100, next id_pc=0x100.
- Redirect to 0x200 in the same cycle as an unstalled completion and id_ready=0 -> id_valid=0 next cycle; next request 0x200.
- PREDECODE_JAL_EN, word 32'h0080006F (jal x0,+8) fetched at 0x40 -> next request 0x48. Without the macro -> next request 0x44.
